// File: rtl/alu_pkg.sv
// Shared ALU-side definitions: serializer state encoding, byte width and the
// bytes-per-result derivation used by the blocks downstream of the ALU.
package alu_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_e;

  // Bytes needed to carry one 2*width-bit ALU result.
  function automatic int nbytes(input int width);
    return (2 * width) / BYTE_W;
  endfunction

endpackage

// File: rtl/res_hold_reg.sv
// One-entry result buffer: load writes and marks valid, take frees the entry.
// A load in the same cycle as a take leaves the entry valid with the new data.
module res_hold_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         RST,
  input  logic         load,
  input  logic         take,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         vld
);

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      dout <= '0;
      vld  <= 1'b0;
    end else begin
      if (load) begin
        dout <= din;
        vld  <= 1'b1;
      end else if (take) begin
        vld  <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_result_serializer.sv
// Splits each captured 2*WIDTH-bit ALU result into bytes, LSB first, for the
// UART TX path; buffers one extra result and flags results lost to overrun.
module alu_result_serializer
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               RST,
  input  logic [2*WIDTH-1:0] ALU_OUT,
  input  logic               ALU_VALID,
  output logic [7:0]         TX_DATA,
  output logic               TX_VALID,
  input  logic               TX_READY,
  output logic               BUSY,
  output logic               OVERRUN,
  input  logic               OVR_CLR
);

  localparam int RW     = 2 * WIDTH;
  localparam int NBYTES = nbytes(WIDTH);
  localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

  if ((RW % BYTE_W) != 0) begin : g_width_chk
    $error("alu_result_serializer: 2*WIDTH must be a multiple of 8");
  end

  ser_state_e    state;
  logic [RW-1:0] shift;
  logic [CW-1:0] cnt;

  logic [RW-1:0] hold_data;
  logic          hold_vld;
  logic          hs, last_hs;
  logic          take, direct, hold_load, drop;

  assign hs      = (state == SEND) && TX_READY;
  assign last_hs = hs && (cnt == LAST);

  // Reload priority at the last byte: held result first, then a fresh one.
  assign take      = last_hs && hold_vld;
  assign direct    = last_hs && !hold_vld && ALU_VALID;
  assign hold_load = (state == SEND) && ALU_VALID && !direct && (!hold_vld || take);
  assign drop      = (state == SEND) && ALU_VALID && hold_vld && !take;

  res_hold_reg #(.W(RW)) u_hold (
    .clk  (clk),
    .RST  (RST),
    .load (hold_load),
    .take (take),
    .din  (ALU_OUT),
    .dout (hold_data),
    .vld  (hold_vld)
  );

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state   <= IDLE;
      shift   <= '0;
      cnt     <= '0;
      OVERRUN <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ALU_VALID) begin
            shift <= ALU_OUT;
            cnt   <= '0;
            state <= SEND;
          end
        end
        SEND: begin
          if (hs) begin
            if (cnt != LAST) begin
              shift <= shift >> BYTE_W;
              cnt   <= cnt + CW'(1);
            end else if (hold_vld) begin
              shift <= hold_data;
              cnt   <= '0;
            end else if (ALU_VALID) begin
              shift <= ALU_OUT;
              cnt   <= '0;
            end else begin
              shift <= '0;
              cnt   <= '0;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase

      if (drop)         OVERRUN <= 1'b1;
      else if (OVR_CLR) OVERRUN <= 1'b0;
    end
  end

  assign TX_DATA  = shift[BYTE_W-1:0];
  assign TX_VALID = (state == SEND);
  assign BUSY     = (state == SEND) | hold_vld;

endmodule

// File: tb/tb_alu_result_serializer.sv
// Directed bench for alu_result_serializer at the default WIDTH=16.
module tb_alu_result_serializer;

  logic        clk = 1'b0;
  logic        RST = 1'b0;
  logic [31:0] ALU_OUT = '0;
  logic        ALU_VALID = 1'b0;
  logic [7:0]  TX_DATA;
  logic        TX_VALID;
  logic        TX_READY = 1'b0;
  logic        BUSY;
  logic        OVERRUN;
  logic        OVR_CLR = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  alu_result_serializer #(.WIDTH(16)) dut (
    .clk       (clk),
    .RST       (RST),
    .ALU_OUT   (ALU_OUT),
    .ALU_VALID (ALU_VALID),
    .TX_DATA   (TX_DATA),
    .TX_VALID  (TX_VALID),
    .TX_READY  (TX_READY),
    .BUSY      (BUSY),
    .OVERRUN   (OVERRUN),
    .OVR_CLR   (OVR_CLR)
  );

  always #5 clk = ~clk;

  // Inputs change 1ns after posedge, so negedge sees what the next edge uses.
  always @(negedge clk)
    if (RST && TX_VALID && TX_READY) got_q.push_back(TX_DATA);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [31:0] d);
    ALU_OUT   = d;
    ALU_VALID = 1'b1;
    cyc();
    ALU_VALID = 1'b0;
  endtask

  task automatic add_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) exp_q.push_back(w[8*i +: 8]);
  endtask

  // Counts cycles with TX_VALID high until it drops; bounded.
  task automatic drain(output int n);
    n = 0;
    while (TX_VALID && n < 200) begin
      n++;
      cyc();
    end
    if (n >= 200) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  task automatic cmp_q(input string tag);
    chk({tag, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s_b%0d", tag, i), {24'd0, got_q[i]}, {24'd0, exp_q[i]});
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int n;
    logic [7:0] ref_b[4];

    // Reset state
    cyc(); cyc();
    chk("rst_txvalid", TX_VALID, 0);
    chk("rst_txdata", TX_DATA, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_overrun", OVERRUN, 0);
    RST = 1'b1;
    cyc();

    // Single result, latency 1, LSB first, back-to-back
    TX_READY = 1'b1;
    ref_b = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
    pulse(32'hA1B2C3D4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("single_vld%0d", i), TX_VALID, 1);
      chk($sformatf("single_data%0d", i), TX_DATA, ref_b[i]);
      cyc();
    end
    chk("single_end_vld", TX_VALID, 0);
    chk("single_end_busy", BUSY, 0);
    got_q.delete();

    // Backpressure on byte 2
    pulse(32'hA1B2C3D4);
    cyc();
    TX_READY = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk($sformatf("bp_hold_data%0d", i), TX_DATA, 8'hC3);
      chk($sformatf("bp_hold_vld%0d", i), TX_VALID, 1);
    end
    TX_READY = 1'b1;
    drain(n);
    add_word(32'hA1B2C3D4);
    cmp_q("bp");

    // Hold buffering, no gap between packets
    pulse(32'h11223344);
    cyc();
    pulse(32'h55667788);
    n = 2;
    begin
      int m;
      drain(m);
      n += m;
    end
    chk("hold_gapless_cycles", n, 8);
    chk("hold_overrun", OVERRUN, 0);
    add_word(32'h11223344);
    add_word(32'h55667788);
    cmp_q("hold");

    // Overrun, clear, and set-wins-over-clear
    TX_READY = 1'b0;
    pulse(32'h04030201);
    pulse(32'h08070605);
    chk("ovr_before", OVERRUN, 0);
    pulse(32'hDEADBEEF);
    chk("ovr_set", OVERRUN, 1);
    chk("ovr_busy", BUSY, 1);
    OVR_CLR = 1'b1;
    cyc();
    OVR_CLR = 1'b0;
    chk("ovr_clr", OVERRUN, 0);
    OVR_CLR = 1'b1;
    pulse(32'hCAFEF00D);
    OVR_CLR = 1'b0;
    chk("ovr_set_wins", OVERRUN, 1);
    TX_READY = 1'b1;
    drain(n);
    add_word(32'h04030201);
    add_word(32'h08070605);
    cmp_q("ovr");
    OVR_CLR = 1'b1;
    cyc();
    OVR_CLR = 1'b0;

    // New result on the last-byte handshake with hold full
    pulse(32'h13121110);
    pulse(32'h17161514);
    cyc(); cyc();
    pulse(32'h1B1A1918);
    chk("coinc_overrun", OVERRUN, 0);
    drain(n);
    chk("coinc_overrun_end", OVERRUN, 0);
    add_word(32'h13121110);
    add_word(32'h17161514);
    add_word(32'h1B1A1918);
    cmp_q("coinc");

    // Reset mid-packet
    pulse(32'hA1B2C3D4);
    cyc(); cyc();
    RST = 1'b0;
    #1;
    chk("midrst_vld", TX_VALID, 0);
    chk("midrst_busy", BUSY, 0);
    chk("midrst_data", TX_DATA, 0);
    cyc();
    RST = 1'b1;
    got_q.delete();
    cyc();
    pulse(32'h9C9D9E9F);
    chk("postrst_first", TX_DATA, 8'h9F);
    drain(n);
    add_word(32'h9C9D9E9F);
    cmp_q("postrst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=%0d", checks, 0);
    $fatal(1);
  end

endmodule

// File: doc/alu_result_serializer.md
Name: alu_result_serializer

Overview:
- Downstream consumer of the ALU comparison/arithmetic output stage.
- Captures each registered 2*WIDTH-bit ALU result on its valid flag and splits it into bytes, LSB first.
- Hands the bytes to the UART transmit path over a valid/ready handshake.
- Holds one extra result while a transfer is in flight; flags results lost to overrun.

Parameters:
- WIDTH, 16: ALU operand width. Result width is 2*WIDTH. 2*WIDTH must be a multiple of 8; elaboration error otherwise.
- NBYTES, 2*WIDTH/8: derived localparam, not overridable. Bytes per result, 4 at default.

Ports:
- clk  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-low reset.
- ALU_OUT  in  2*WIDTH  registered ALU result.
- ALU_VALID  in  1  one-cycle pulse; ALU_OUT is valid in the same cycle.
- TX_DATA  out  8  byte to the UART TX path.
- TX_VALID  out  1  TX_DATA is valid.
- TX_READY  in  1  sink accepts the byte; a transfer occurs on TX_VALID && TX_READY at the clock edge.
- BUSY  out  1  a transfer is in progress or the hold register is occupied.
- OVERRUN  out  1  sticky; a result was dropped.
- OVR_CLR  in  1  synchronous clear of OVERRUN.

Behaviour:
- Reset (async assert, sync release): state=IDLE; shift register, byte counter, hold register and hold-valid all 0. Outputs TX_DATA=0, TX_VALID=0, BUSY=0, OVERRUN=0. Reset mid-packet abandons the packet with no further bytes sent.
- States: IDLE, SEND.
- IDLE:
  - ALU_VALID=1: load ALU_OUT into the shift register, counter=0, go to SEND.
  - TX_VALID rises the cycle after capture (latency 1).
- SEND:
  - TX_VALID=1 and TX_DATA=shift[7:0].
  - While TX_READY=0, TX_DATA and TX_VALID are held stable.
  - Handshake with counter<NBYTES-1: shift right by 8, counter+1.
  - Handshake with counter==NBYTES-1 (last byte), reload priority: (1) hold register if valid; hold-valid clears unless refilled the same cycle. (2) Otherwise ALU_OUT if ALU_VALID is present this cycle. (3) Otherwise go to IDLE and drop TX_VALID next cycle.
  - Any reload sets counter=0 and stays in SEND, so bytes go back-to-back with no gap.
- ALU_VALID while in SEND (and not consumed as a direct reload):
  - Hold register empty: store ALU_OUT, set hold-valid.
  - Hold register full and no last-byte handshake this cycle: drop the new result and set OVERRUN.
  - Hold register full and last-byte handshake this cycle: the hold register moves to the shift register and the new result enters the hold register. No overrun.
- BUSY = (state==SEND) | hold-valid. Registered-state derived, no combinational path from inputs.
- OVERRUN is set by a drop and cleared by OVR_CLR. If both occur in the same cycle, set wins.
- TX_READY while TX_VALID=0 is ignored.
- Byte order is fixed LSB first. For the default configuration: ALU_OUT[7:0], [15:8], [23:16], [31:24].

Decomposition:
- Shared package alu_pkg holds:
  - state encoding typedef/localparams (IDLE=1'b0, SEND=1'b1);
  - BYTE_W=8;
  - the NBYTES derivation function, reused by other ALU-side blocks.
- One natural sub-module: res_hold_reg, a one-entry 2*WIDTH register with load/take/valid.
- The FSM, shift register and counter stay in the top module.

Test Plan:
- Reset then single result: ALU_OUT=32'hA1B2C3D4 pulsed, TX_READY=1 -> TX_VALID rises 1 cycle later; bytes D4, C3, B2, A1 on 4 consecutive cycles; then TX_VALID=0 and BUSY=0.
- Backpressure: TX_READY=0 for 5 cycles on byte 2 -> TX_DATA held at C3 with TX_VALID=1; all 4 bytes delivered exactly once, in order.
- Hold buffering: result 32'h11223344, then 32'h55667788 two cycles later, TX_READY=1 -> 8 bytes 44,33,22,11,88,77,66,55 with no idle cycle between packets; OVERRUN=0.
- Overrun: three results pulsed within the first packet with TX_READY=0 -> third dropped and OVERRUN=1. After OVR_CLR, OVERRUN=0. Assert OVR_CLR on the same cycle as another drop -> OVERRUN stays 1.
- Last-byte coincidence: hold full and a new ALU_VALID on the cycle of the last-byte handshake -> no overrun; both queued packets are sent in order.
- Reset mid-packet: assert RST after 2 bytes -> TX_VALID=0 and BUSY=0 immediately. A new result after reset release starts at its byte 0.
